// File: rtl/ccip_if_pkg.sv
// ============================================================================
// Module      : ccip_if_pkg
// Description : Platform CCI-P type definitions used by the AFU MMIO blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ccip_if_pkg;

    typedef logic [15:0]  t_ccip_mmioAddr;
    typedef logic [8:0]   t_ccip_tid;
    typedef logic [63:0]  t_ccip_mmioData;
    typedef logic [511:0] t_ccip_clData;

    // MMIO request view of the Rx c0 header
    typedef struct packed {
        t_ccip_mmioAddr address;
        logic [1:0]     length;
        logic           rsvd0;
        t_ccip_tid      tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        t_ccip_tid tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        logic [27:0]  hdr;
        t_ccip_clData data;
        logic         rspValid;
        logic         mmioRdValid;
        logic         mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
        t_if_ccip_c0_Rx c0;
    } t_if_ccip_Rx;

    typedef struct packed {
        logic [73:0] hdr;
        logic        valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        logic [79:0]  hdr;
        t_ccip_clData data;
        logic         valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        t_ccip_mmioData      data;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        t_if_ccip_c0_Tx c0;
        t_if_ccip_c1_Tx c1;
        t_if_ccip_c2_Tx c2;
    } t_if_ccip_Tx;

endpackage

`default_nettype wire

// File: rtl/hello_csr_pkg.sv
// ============================================================================
// Module      : hello_csr_pkg
// Description : Register map, DFH layout and status types for hello_mmio_csr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hello_csr_pkg;

    // Word addresses (4-byte units)
    localparam logic [15:0] c_ADDR_DFH       = 16'h0000;
    localparam logic [15:0] c_ADDR_AFU_ID_L  = 16'h0002;
    localparam logic [15:0] c_ADDR_AFU_ID_H  = 16'h0004;
    localparam logic [15:0] c_ADDR_NEXT_AFU  = 16'h0006;
    localparam logic [15:0] c_ADDR_RSVD      = 16'h0008;
    localparam logic [15:0] c_ADDR_SCRATCH   = 16'h000A;
    localparam logic [15:0] c_ADDR_CYCLE_CNT = 16'h000C;
    localparam logic [15:0] c_ADDR_MMIO_STAT = 16'h000E;

    typedef struct packed {
        logic [3:0]  featureType;
        logic [7:0]  rsvd1;
        logic [3:0]  afuMinor;
        logic [6:0]  rsvd0;
        logic        eol;
        logic [23:0] nextOffset;
        logic [3:0]  afuMajor;
        logic [11:0] featureId;
    } t_dfh;

    // AFU feature, end of list, no successor
    localparam logic [63:0] c_DFH = {4'h1, 8'h0, 4'h0, 7'h0, 1'b1, 24'h0, 4'h0, 12'h0};

    typedef struct packed {
        logic [31:0] writes;
        logic [31:0] reads;
    } t_mmio_stat;

    function automatic logic [14:0] regSel(input logic [15:0] wordAddr);
        return wordAddr[15:1];
    endfunction

endpackage

`default_nettype wire

// File: rtl/hello_mmio_csr.sv
// ============================================================================
// Module      : hello_mmio_csr
// Description : AFU CSR block: DFH, AFU ID, scratch, cycle and access counters
//               with a fixed two-stage MMIO read response pipeline on c2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hello_mmio_csr
    import ccip_if_pkg::*;
    import hello_csr_pkg::*;
#(
    parameter logic [63:0] AFU_ID_H     = 64'h0,
    parameter logic [63:0] AFU_ID_L     = 64'h0,
    parameter logic [63:0] SCRATCH_INIT = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  t_if_ccip_Rx cp2af_sRxPort,
    output t_if_ccip_Tx af2cp_sTxPort
);

    t_ccip_c0_ReqMmioHdr w_hdr;
    logic                w_rdReq;
    logic                w_wrReq;
    logic                w_is8B;
    logic                w_upperHalf;
    logic [14:0]         w_sel;
    logic [63:0]         w_regVal;
    logic [63:0]         w_rdData;
    logic [63:0]         w_wrData;
    logic                w_unused;

    logic [63:0]         r_scratch;
    logic [63:0]         r_cycleCnt;
    t_mmio_stat          r_stat;
    logic                r_s1Valid;
    t_ccip_tid           r_s1Tid;
    logic [63:0]         r_s1Data;
    logic                r_c2Valid;
    t_ccip_tid           r_c2Tid;
    logic [63:0]         r_c2Data;

    assign w_hdr       = t_ccip_c0_ReqMmioHdr'(cp2af_sRxPort.c0.hdr);
    assign w_rdReq     = cp2af_sRxPort.c0.mmioRdValid & ~reset;
    assign w_wrReq     = cp2af_sRxPort.c0.mmioWrValid & ~reset;
    assign w_is8B      = (w_hdr.length != 2'd0);
    assign w_upperHalf = w_hdr.address[0];
    assign w_sel       = regSel(w_hdr.address);
    assign w_wrData    = cp2af_sRxPort.c0.data[63:0];

    assign w_unused = ^{cp2af_sRxPort.c0.data[511:64], cp2af_sRxPort.c0.rspValid,
                        cp2af_sRxPort.c0TxAlmFull, cp2af_sRxPort.c1TxAlmFull, w_hdr.rsvd0};

    always_comb begin
        w_regVal = 64'h0;
        case (w_sel)
            regSel(c_ADDR_DFH):       w_regVal = c_DFH;
            regSel(c_ADDR_AFU_ID_L):  w_regVal = AFU_ID_L;
            regSel(c_ADDR_AFU_ID_H):  w_regVal = AFU_ID_H;
            regSel(c_ADDR_SCRATCH):   w_regVal = r_scratch;
            regSel(c_ADDR_CYCLE_CNT): w_regVal = r_cycleCnt;
            regSel(c_ADDR_MMIO_STAT): w_regVal = r_stat;
            default:                  w_regVal = 64'h0;
        endcase
    end

    // 4B reads return the selected half zero-extended
    always_comb begin
        w_rdData = w_regVal;
        if (!w_is8B) begin
            w_rdData = w_upperHalf ? {32'h0, w_regVal[63:32]} : {32'h0, w_regVal[31:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_scratch <= SCRATCH_INIT;
        end else if (w_wrReq && (w_sel == regSel(c_ADDR_SCRATCH))) begin
            if (w_is8B) begin
                r_scratch <= w_wrData;
            end else if (w_upperHalf) begin
                r_scratch[63:32] <= w_wrData[31:0];
            end else begin
                r_scratch[31:0] <= w_wrData[31:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || (w_wrReq && (w_sel == regSel(c_ADDR_CYCLE_CNT)))) begin
            r_cycleCnt <= 64'h0;
        end else begin
            r_cycleCnt <= r_cycleCnt + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat <= '0;
        end else begin
            r_stat.reads  <= r_stat.reads + {31'h0, w_rdReq};
            r_stat.writes <= r_stat.writes + {31'h0, w_wrReq};
        end
    end

    // Read pipeline; reset discards anything in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1Valid <= 1'b0;
            r_c2Valid <= 1'b0;
        end else begin
            r_s1Valid <= w_rdReq;
            r_c2Valid <= r_s1Valid;
        end
        r_s1Tid  <= w_hdr.tid;
        r_s1Data <= w_rdData;
        r_c2Tid  <= r_s1Tid;
        r_c2Data <= r_s1Data;
    end

    always_comb begin
        af2cp_sTxPort                = '0;
        af2cp_sTxPort.c2.mmioRdValid = r_c2Valid;
        af2cp_sTxPort.c2.hdr.tid     = r_c2Tid;
        af2cp_sTxPort.c2.data        = r_c2Data;
    end

endmodule

`default_nettype wire
